// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display paths: segment bit positions,
// the blank glyph, the unknown-character code and the decoder state enum.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_BLANK     = 7'h7F;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_to_ascii.sv
// Combinational glyph-to-ASCII lookup for active-low segment codes.
// Glyphs shared by a letter and a digit are resolved by num_mode.
module seg7_to_ascii
    import seg7_pkg::*;
(
    input  logic [6:0] seg_code,
    input  logic       num_mode,
    output logic [7:0] ascii,
    output logic       unknown
);

    always_comb begin
        ascii   = ASCII_UNKNOWN;
        unknown = 1'b0;
        case (seg_code)
            7'h08:     ascii = 8'h41;
            7'h03:     ascii = 8'h42;
            7'h46:     ascii = 8'h43;
            7'h21:     ascii = 8'h44;
            7'h06:     ascii = 8'h45;
            7'h0E:     ascii = 8'h46;
            7'h61:     ascii = 8'h4A;
            7'h47:     ascii = 8'h4C;
            7'h6A:     ascii = 8'h4D;
            7'h2B:     ascii = 8'h4E;
            7'h0C:     ascii = 8'h50;
            7'h18:     ascii = 8'h51;
            7'h2F:     ascii = 8'h52;
            7'h07:     ascii = 8'h54;
            7'h41:     ascii = 8'h55;
            7'h63:     ascii = 8'h56;
            7'h55:     ascii = 8'h57;
            7'h11:     ascii = 8'h59;
            // H, K and X cannot be told apart on a 7-segment panel
            7'h09:     ascii = 8'h48;
            7'h79:     ascii = 8'h31;
            7'h19:     ascii = 8'h34;
            7'h02:     ascii = 8'h36;
            7'h78:     ascii = 8'h37;
            7'h00:     ascii = 8'h38;
            SEG_BLANK: ascii = 8'h20;
            7'h40:     ascii = num_mode ? 8'h30 : 8'h4F;
            7'h24:     ascii = num_mode ? 8'h32 : 8'h5A;
            7'h30:     ascii = num_mode ? 8'h33 : 8'h49;
            7'h12:     ascii = num_mode ? 8'h35 : 8'h53;
            7'h10:     ascii = num_mode ? 8'h39 : 8'h47;
            default:   unknown = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_ascii_decoder.sv
// Collects MSG_LEN decoded glyphs into one message word (first char in the
// top byte) and hands it downstream on a valid/ready handshake.
module seg7_ascii_decoder
    import seg7_pkg::*;
#(
    parameter int MSG_LEN = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   seg_valid,
    output logic                   seg_ready,
    input  logic [6:0]             seg_code,
    input  logic                   num_mode,
    input  logic                   flush,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output logic [8*MSG_LEN-1:0]   msg_data,
    output logic                   msg_err
);

    localparam int CW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [7:0]      ascii;
    logic            unknown;

    seg7_to_ascii u_lookup (
        .seg_code (seg_code),
        .num_mode (num_mode),
        .ascii    (ascii),
        .unknown  (unknown)
    );

    // Handshake flags come straight from the state register, so msg_ready
    // never reaches seg_ready combinationally.
    assign seg_ready = (state == FILL);
    assign msg_valid = (state == FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FILL;
            cnt      <= '0;
            msg_data <= '0;
            msg_err  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (flush) begin
                        cnt      <= '0;
                        msg_data <= '0;
                        msg_err  <= 1'b0;
                    end else if (seg_valid) begin
                        msg_data[8*(MSG_LEN-1-int'(cnt)) +: 8] <= ascii;
                        msg_err <= msg_err | unknown;
                        if (cnt == CW'(MSG_LEN-1)) begin
                            state <= FULL;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                FULL: begin
                    if (msg_ready) begin
                        state    <= FILL;
                        msg_data <= '0;
                        msg_err  <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_ascii_decoder.sv
// Self-checking bench for seg7_ascii_decoder: table of whole messages checked
// through a scoreboard queue, plus hand sequences for latency, backpressure,
// flush and asynchronous reset.
module tb_seg7_ascii_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        seg_valid = 1'b0;
    logic        seg_ready;
    logic [6:0]  seg_code = 7'h7F;
    logic        num_mode = 1'b0;
    logic        flush = 1'b0;
    logic        msg_valid;
    logic        msg_ready = 1'b0;
    logic [39:0] msg_data;
    logic        msg_err;

    int num_tests = 0;
    int num_fail  = 0;

    typedef struct {
        logic [34:0] glyphs;
        logic        nm;
        logic [39:0] data;
        logic        err;
    } vec_t;

    typedef struct {
        logic [39:0] data;
        logic        err;
    } exp_t;

    vec_t vectors[10];
    exp_t exp_q[$];

    seg7_ascii_decoder #(.MSG_LEN(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_valid (seg_valid),
        .seg_ready (seg_ready),
        .seg_code  (seg_code),
        .num_mode  (num_mode),
        .flush     (flush),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_data  (msg_data),
        .msg_err   (msg_err)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] pack5(input logic [6:0] g0, input logic [6:0] g1,
                                          input logic [6:0] g2, input logic [6:0] g3,
                                          input logic [6:0] g4);
        return {g0, g1, g2, g3, g4};
    endfunction

    task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] req);
        num_tests++;
        if (act !== req) begin
            num_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive one glyph and hold it until accepted, bounded so a stuck DUT cannot hang the run.
    task automatic applyStimulus(input logic [6:0] code, input logic nm);
        int waited = 0;
        seg_valid = 1'b1;
        seg_code  = code;
        num_mode  = nm;
        @(negedge clk);
        while (!seg_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!seg_ready) begin
            num_tests++;
            num_fail++;
            $display("[TB] FAIL accept_timeout: got seg_ready=0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
    endtask

    task automatic sendMessage(input logic [34:0] g, input logic nm);
        for (int j = 0; j < 5; j++) begin
            applyStimulus(g[34-7*j -: 7], nm);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && msg_valid && msg_ready) begin
            if (exp_q.size() == 0) begin
                num_tests++;
                num_fail++;
                $display("[TB] FAIL unexpected_msg: got %h, expected no message", msg_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("msg_data", msg_data, e.data);
                checkOutput("msg_err", {39'd0, msg_err}, {39'd0, e.err});
            end
        end
    end

    initial begin
        vectors[0] = '{pack5(7'h09, 7'h06, 7'h47, 7'h47, 7'h40), 1'b0, 40'h48454C4C4F, 1'b0};
        vectors[1] = '{pack5(7'h40, 7'h79, 7'h24, 7'h30, 7'h19), 1'b1, 40'h3031323334, 1'b0};
        vectors[2] = '{pack5(7'h40, 7'h79, 7'h24, 7'h30, 7'h19), 1'b0, 40'h4F315A4934, 1'b0};
        vectors[3] = '{pack5(7'h08, 7'h01, 7'h7F, 7'h7F, 7'h7F), 1'b0, 40'h413F202020, 1'b1};
        vectors[4] = '{pack5(7'h08, 7'h03, 7'h46, 7'h21, 7'h06), 1'b0, 40'h4142434445, 1'b0};
        vectors[5] = '{pack5(7'h0E, 7'h61, 7'h47, 7'h6A, 7'h2B), 1'b0, 40'h464A4C4D4E, 1'b0};
        vectors[6] = '{pack5(7'h0C, 7'h18, 7'h2F, 7'h07, 7'h41), 1'b0, 40'h5051525455, 1'b0};
        vectors[7] = '{pack5(7'h63, 7'h55, 7'h11, 7'h02, 7'h00), 1'b1, 40'h5657593638, 1'b0};
        vectors[8] = '{pack5(7'h78, 7'h7F, 7'h12, 7'h10, 7'h09), 1'b0, 40'h3720534748, 1'b0};
        vectors[9] = '{pack5(7'h12, 7'h10, 7'h09, 7'h00, 7'h7E), 1'b1, 40'h394838003F >> 0, 1'b1};
        vectors[9].data = 40'h353948383F;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_seg_ready", {39'd0, seg_ready}, 40'd1);
        checkOutput("rst_msg_valid", {39'd0, msg_valid}, 40'd0);
        checkOutput("rst_msg_data", msg_data, 40'd0);
        checkOutput("rst_msg_err", {39'd0, msg_err}, 40'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table of complete messages at full rate with the consumer always ready
        msg_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_t e;
            e.data = vectors[i].data;
            e.err  = vectors[i].err;
            exp_q.push_back(e);
            sendMessage(vectors[i].glyphs, vectors[i].nm);
        end
        repeat (3) @(posedge clk);
        #1;

        // Latency, partial fill and backpressure
        msg_ready = 1'b0;
        applyStimulus(7'h09, 1'b0);
        applyStimulus(7'h06, 1'b0);
        checkOutput("partial_data", msg_data, 40'h4845000000);
        applyStimulus(7'h47, 1'b0);
        applyStimulus(7'h47, 1'b0);
        checkOutput("valid_before_last", {39'd0, msg_valid}, 40'd0);
        applyStimulus(7'h40, 1'b0);
        checkOutput("valid_after_last", {39'd0, msg_valid}, 40'd1);
        checkOutput("ready_after_last", {39'd0, seg_ready}, 40'd0);
        seg_valid = 1'b1;
        seg_code  = 7'h08;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("bp_seg_ready", {39'd0, seg_ready}, 40'd0);
            checkOutput("bp_data_stable", msg_data, 40'h48454C4C4F);
        end
        // Flush while FULL must leave the pending message untouched
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_full_valid", {39'd0, msg_valid}, 40'd1);
        checkOutput("flush_full_data", msg_data, 40'h48454C4C4F);
        exp_q.push_back('{40'h48454C4C4F, 1'b0});
        msg_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("handoff_seg_ready", {39'd0, seg_ready}, 40'd1);
        checkOutput("handoff_data_clear", msg_data, 40'd0);
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
        checkOutput("next_glyph_accepted", msg_data, 40'h4100000000);

        // Flush discards a partial message including its error flag
        applyStimulus(7'h01, 1'b0);
        applyStimulus(7'h46, 1'b0);
        checkOutput("partial_err", {39'd0, msg_err}, 40'd1);
        flush     = 1'b1;
        seg_valid = 1'b1;
        seg_code  = 7'h7F;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        seg_valid = 1'b0;
        checkOutput("flush_data", msg_data, 40'd0);
        checkOutput("flush_err", {39'd0, msg_err}, 40'd0);
        checkOutput("flush_seg_ready", {39'd0, seg_ready}, 40'd1);
        exp_q.push_back('{40'h48454C4C4F, 1'b0});
        sendMessage(vectors[0].glyphs, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a message
        applyStimulus(7'h01, 1'b0);
        applyStimulus(7'h08, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("async_seg_ready", {39'd0, seg_ready}, 40'd1);
        checkOutput("async_msg_valid", {39'd0, msg_valid}, 40'd0);
        checkOutput("async_msg_data", msg_data, 40'd0);
        checkOutput("async_msg_err", {39'd0, msg_err}, 40'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back('{40'h4142434445, 1'b0});
        sendMessage(vectors[4].glyphs, 1'b0);

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
        @(negedge clk);
        checkOutput("scoreboard_drained", 40'(exp_q.size()), 40'd0);

        $display("[TB] %0d tests run, %0d failed", num_tests, num_fail);
        $finish;
    end

endmodule
